// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-way round-robin arbiter.
package arb_pkg;
    typedef enum logic {IDLE, GRANT} state_t;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;
endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search: last_idx+1 is favoured, last_idx itself comes last.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);
    logic [IDX_W-1:0] cand;

    // Scan from lowest to highest priority so the best candidate lands last.
    always_comb begin
        win_idx   = last_idx;
        win_valid = 1'b0;
        cand      = last_idx;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = last_idx + IDX_W'(k);
            if (req[cand]) begin
                win_idx   = cand;
                win_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered owner index.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] pick_last, win_idx;
    logic             win_valid;
    logic             vol_rel, force_rel, release_now;
    logic             grant_start;

    // On a release edge the current owner already counts as the last served.
    assign pick_last = (state_q == GRANT) ? idx_q : last_q;

    rr_pick4 u_pick (
        .req       (req),
        .last_idx  (pick_last),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    assign vol_rel     = ~req[idx_q] | rel;
    assign release_now = vol_rel | force_rel;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_q;
    logic             timeout_q;

    assign force_rel = (hold_q == HOLD_LAST) & ~vol_rel;
    assign timeout   = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state_q == GRANT) & force_rel;
            if (grant_start)
                hold_q <= '0;
            else if (state_q == GRANT)
                hold_q <= hold_q + 1'b1;
        end
    end
`else
    logic [CNT_W:0] unused_hold;

    assign force_rel   = 1'b0;
    assign timeout     = 1'b0;
    assign unused_hold = {grant_start, CNT_W'(MAX_HOLD)};
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        grant_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d     = GRANT;
                    idx_d       = win_idx;
                    grant_start = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_d      = idx_q;
                    grant_start = win_valid;
                    if (win_valid)
                        idx_d = win_idx;
                    else
                        state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;
    assign gnt       = gnt_valid ? (N_REQ'(1) << idx_q) : '0;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: directed vectors queue expectations,
// a monitor pops and compares them after each edge or on async reset.
module tb_rr_arbiter4;
    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic       rel   = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter4 #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       v;
        logic       to;
        logic       chk_idx;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            if (gnt !== e.gnt || gnt_valid !== e.v || timeout !== e.to ||
                (e.chk_idx && gnt_idx !== e.idx)) begin
                n_bad++;
                $display("FAIL %s: got gnt=%b valid=%b idx=%0d timeout=%b, want gnt=%b valid=%b idx=%0d timeout=%b",
                         e.nm, gnt, gnt_valid, gnt_idx, timeout,
                         e.gnt, e.v, e.idx, e.to);
            end
        end
    end

    function automatic exp_t mk(input int c, input logic [3:0] eg,
                                input logic et, input string nm);
        exp_t e;
        e.cyc     = c;
        e.gnt     = eg;
        e.v       = |eg;
        e.to      = et;
        e.chk_idx = |eg;
        e.idx     = 2'd0;
        for (int i = 0; i < 4; i++)
            if (eg[i]) e.idx = 2'(i);
        e.nm = nm;
        return e;
    endfunction

    function automatic exp_t mk_rst(input int c, input string nm);
        exp_t e;
        e         = mk(c, 4'b0000, 1'b0, nm);
        e.chk_idx = 1'b1;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [3:0] r, input logic rl,
                        input logic [3:0] eg, input logic et,
                        input string nm);
        req = r;
        rel = rl;
        q.push_back(mk(cyc + 1, eg, et, nm));
        @(posedge clk);
        #1;
    endtask

    logic [3:0] fair_g [12] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                4'b0010, 4'b0100, 4'b0100, 4'b0100,
                                4'b1000, 4'b1000, 4'b1000, 4'b0001};

    initial begin
        logic [3:0] eg;
        logic       et;

        @(posedge clk);
        #1;
        q.push_back(mk_rst(cyc, "reset_state"));
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        step(4'b1111, 1'b0, 4'b0001, 1'b0, "reset_prio");
        step(4'b1110, 1'b0, 4'b0010, 1'b0, "drop_handoff");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle_return");
        step(4'b0000, 1'b1, 4'b0000, 1'b0, "rel_in_idle");
        step(4'b0001, 1'b0, 4'b0001, 1'b0, "idle_regrant");

        for (int k = 0; k < 12; k++)
            step(4'b1111, (k % 3) == 2, fair_g[k], 1'b0, "fairness");

        step(4'b0011, 1'b0, 4'b0001, 1'b0, "no_queue_a");
        step(4'b0001, 1'b0, 4'b0001, 1'b0, "no_queue_b");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "no_queue_c");

        step(4'b0100, 1'b0, 4'b0100, 1'b0, "sole_grant");
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "sole_hold1");
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "sole_hold2");
        step(4'b0100, 1'b1, 4'b0100, 1'b0, "sole_rel");
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "sole_cnt1");
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "sole_cnt2");
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "sole_cnt3");
        step(4'b0100, 1'b0, 4'b0100, TO_EN, "sole_force");
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "sole_after");

        step(4'b0000, 1'b0, 4'b0000, 1'b0, "drop_idle");
        step(4'b0001, 1'b0, 4'b0001, 1'b0, "to_start");
        for (int k = 0; k < 22; k++) begin
            if (TO_EN) begin
                eg = (((k + 1) / 4) % 2) ? 4'b1000 : 4'b0001;
                et = (k % 4) == 3;
            end else begin
                eg = 4'b0001;
                et = 1'b0;
            end
            step(4'b1001, 1'b0, eg, et, "hold_timeout");
        end

        step(4'b0000, 1'b0, 4'b0000, 1'b0, "end_idle");
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "pre_rst");

        @(negedge clk);
        #2;
        q.push_back(mk_rst(cyc, "async_rst"));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0100, 1'b0, 4'b0100, 1'b0, "rst_regrant");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "final_idle");

        @(negedge clk);
        #3;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one single-owner resource (e.g. a bus or ALU port) between requesters 0..3.
- Holds the winner as a registered 2-bit index.
- Drives a one-hot grant by decoding that index, with gnt_valid as the decode enable.
- Sits between the requesting lab sub-blocks and the shared resource's select/enable logic.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per ownership. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[i] is held high by requester i while it wants or uses the resource.
- rel  input  1  release pulse from the current owner; high for 1 cycle ends ownership even if req stays high.
- gnt  output  4  one-hot grant; all zero when gnt_valid=0.
- gnt_idx  output  2  index of the current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  resource is owned.
- timeout  output  1  1-cycle pulse on a forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset:
  - Asynchronous assert (rst_n=0), effective immediately, including mid-grant.
  - Values: state=IDLE, gnt=4'b0000, gnt_idx=2'd0, gnt_valid=0, timeout=0, last_idx=2'd3 (requester 0 has top priority after reset), hold counter=0.
  - Release of rst_n is assumed synchronous to clk externally.
- States: IDLE (no owner), GRANT (owner = gnt_idx).
- Priority order: last_idx+1, +2, +3, +0 (mod 4). The most recently served requester is always lowest priority.
- IDLE:
  - If req != 0, pick the winner by priority order; next edge: GRANT, gnt_idx=winner, gnt_valid=1.
  - Latency is exactly 1 cycle from req sampled high to gnt high.
  - If req == 0, stay in IDLE.
- GRANT:
  - Ownership ends on the first edge where any of these hold:
    - req[gnt_idx]=0
    - rel=1
    - forced timeout (ARB_TIMEOUT_EN only)
  - On that edge:
    - last_idx ← gnt_idx.
    - The winner among current req (with the new priority order) is computed in the same cycle.
    - If there is a winner, stay in GRANT with the new gnt_idx. Handoff is back-to-back with no dead cycle.
    - If there is no winner, go to IDLE with gnt_valid=0.
  - If rel=1 while req[gnt_idx] is still 1 and no other requester is pending, the same requester is re-granted on the next edge.
  - rel while in IDLE is ignored.
  - Requests from non-owners while in GRANT are only sampled at a release edge. They are not queued.
- gnt is combinational from registered state: gnt[i] = gnt_valid & (gnt_idx == i). It is glitch-free relative to the clock edge.
- Invariants: at most one gnt bit is high; gnt_valid=0 implies gnt=0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every grant start (including re-grant and handoff) and increments each GRANT cycle.
  - When the counter equals MAX_HOLD-1 and there is no voluntary release that cycle, the next edge forces a release.
  - That forced release has the same handoff rules as a voluntary one, and the offending requester becomes lowest priority.
  - timeout=1 for exactly the cycle after the forced edge.
  - If a voluntary release and the timeout coincide, it is treated as voluntary and timeout stays 0.
- Undefined:
  - No counter is present, and timeout is tied to 0.
  - Ownership lasts until req drops or rel.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, GRANT}
  - N_REQ=4, IDX_W=2
  - localparam CNT_W=8
- Sub-module rr_pick4 (combinational):
  - Inputs: req[3:0], last_idx[1:0].
  - Outputs: win_idx[1:0], win_valid.
  - Rotating-priority search used for both IDLE and handoff decisions.

Test Plan:
- Reset priority: after reset, req=4'b1111 → one cycle later gnt=4'b0001, gnt_idx=0. Drop req[0] → next edge gnt=4'b0010 with no idle cycle.
- Fairness: req=4'b1111 held, rel pulsed every 3rd cycle → grant sequence 0,1,2,3,0 with each grant lasting 3 cycles.
- Sole-requester rel: only req[2]=1, rel=1 for one cycle → gnt stays 4'b0100 (re-grant). Hold counter restarts when ARB_TIMEOUT_EN is defined.
- Idle return: owner 1 drops req, req=0 → next edge gnt=0, gnt_valid=0. Then req=4'b0001 → gnt=4'b0001 one cycle later.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=4'b1001, owner 0 never releases → after 4 grant cycles gnt=4'b1000 and timeout=1 for 1 cycle. Without the macro, gnt=4'b0001 held for 20+ cycles with timeout=0.
- Async reset mid-grant: gnt=4'b0100, drive rst_n=0 between edges → gnt=0 and gnt_valid=0 immediately. After release, with req=4'b0100, the grant returns to 2 one cycle later.
